// File: rtl/wb_regfile_pkg.sv
// Shared sizing constants for the write-back register file.
package wb_regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 32;
  localparam int REG_AW     = 5;
  localparam logic [REG_AW-1:0] R0_IDX = 5'd0;
endpackage

// File: rtl/wb_result_mux.sv
// MemtoReg select between load data and ALU result for the write-back stage.
module wb_result_mux #(
  parameter int DATA_W = 32
) (
  input  logic              mem_to_reg_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] alu_out_i,
  output logic [DATA_W-1:0] result_o
);

  // Select the write-back source.
  always_comb begin
    if (mem_to_reg_i) begin
      result_o = mem_data_i;
    end else begin
      result_o = alu_out_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: two read ports, r0 hardwired to zero, retired-write counter.
// Optional write-before-read bypass enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RegWriteW,
  input  logic                MemtoRegW,
  input  logic [DATA_W-1:0]   Data_Mem_Out_W,
  input  logic [DATA_W-1:0]   ALU_Out_W,
  input  logic [REG_AW-1:0]   WriteRegW,
  input  logic [REG_AW-1:0]   A1,
  input  logic [REG_AW-1:0]   A2,
  output logic [DATA_W-1:0]   RD1,
  output logic [DATA_W-1:0]   RD2,
  output logic [DATA_W-1:0]   ResultW,
  output logic [31:0]         wb_count
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [REG_AW:0] NREG_W = (REG_AW + 1)'(NREG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [31:0]       wb_count_q;
  logic [31:0]       wb_count_d;
  logic              wr_en;
  logic              a1_valid;
  logic              a2_valid;
  logic [DATA_W-1:0] rd1_stored;
  logic [DATA_W-1:0] rd2_stored;

  wb_result_mux #(.DATA_W(DATA_W)) u_result_mux (
    .mem_to_reg_i (MemtoRegW),
    .mem_data_i   (Data_Mem_Out_W),
    .alu_out_i    (ALU_Out_W),
    .result_o     (ResultW)
  );

  // r0 and out-of-range addresses are neither stored nor readable.
  assign wr_en    = RegWriteW && (WriteRegW != R0_IDX) && ({1'b0, WriteRegW} < NREG_W);
  assign a1_valid = (A1 != R0_IDX) && ({1'b0, A1} < NREG_W);
  assign a2_valid = (A2 != R0_IDX) && ({1'b0, A2} < NREG_W);

  // Counter next state.
  always_comb begin
    if (wr_en) begin
      wb_count_d = wb_count_q + 32'd1;
    end else begin
      wb_count_d = wb_count_q;
    end
  end

  // Storage and counter update; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= 32'd0;
    end else begin
      if (wr_en) begin
        regs_q[WriteRegW[AW-1:0]] <= ResultW;
      end
      wb_count_q <= wb_count_d;
    end
  end

  // Stored-value reads.
  always_comb begin
    if (a1_valid) begin
      rd1_stored = regs_q[A1[AW-1:0]];
    end else begin
      rd1_stored = '0;
    end
    if (a2_valid) begin
      rd2_stored = regs_q[A2[AW-1:0]];
    end else begin
      rd2_stored = '0;
    end
  end

`ifdef WB_REGFILE_BYPASS_EN
  // Same-cycle forwarding of the value being written.
  always_comb begin
    if (!rst && wr_en && (A1 == WriteRegW)) begin
      RD1 = ResultW;
    end else begin
      RD1 = rd1_stored;
    end
    if (!rst && wr_en && (A2 == WriteRegW)) begin
      RD2 = ResultW;
    end else begin
      RD2 = rd2_stored;
    end
  end
`else
  assign RD1 = rd1_stored;
  assign RD2 = rd2_stored;
`endif

  assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scoreboard bench for wb_regfile.
module tb_wb_regfile;

  typedef struct {
    int          kind;  // 0 RD1, 1 RD2, 2 wb_count, 3 ResultW
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] Data_Mem_Out_W;
  logic [31:0] ALU_Out_W;
  logic [4:0]  WriteRegW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ResultW;
  logic [31:0] wb_count;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  wb_regfile #(.DATA_W(32), .NREG(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .RegWriteW      (RegWriteW),
    .MemtoRegW      (MemtoRegW),
    .Data_Mem_Out_W (Data_Mem_Out_W),
    .ALU_Out_W      (ALU_Out_W),
    .WriteRegW      (WriteRegW),
    .A1             (A1),
    .A2             (A2),
    .RD1            (RD1),
    .RD2            (RD2),
    .ResultW        (ResultW),
    .wb_count       (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input int kind, input string name, input logic [31:0] v);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] wr,
                       input logic [4:0] a1v, input logic [4:0] a2v);
    @(posedge clk);
    #1;
    RegWriteW      = we;
    MemtoRegW      = m2r;
    Data_Mem_Out_W = mem;
    ALU_Out_W      = alu;
    WriteRegW      = wr;
    A1             = a1v;
    A2             = a2v;
  endtask

  // Monitor: compare everything queued for this cycle mid-period.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        0: act = RD1;
        1: act = RD2;
        2: act = wb_count;
        default: act = ResultW;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bypass_exp;
    rst = 1'b1;
    RegWriteW = 1'b0; MemtoRegW = 1'b0;
    Data_Mem_Out_W = 32'd0; ALU_Out_W = 32'd0;
    WriteRegW = 5'd0; A1 = 5'd0; A2 = 5'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: every address reads zero.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(a), 5'(31 - a));
      expect_val(0, "reset_rd1", 32'd0);
      expect_val(1, "reset_rd2", 32'd0);
      expect_val(2, "reset_count", 32'd0);
    end

    drive(1'b1, 1'b0, 32'h0BADF00D, 32'h12345678, 5'd5, 5'd0, 5'd0);
    expect_val(3, "resultw_alu", 32'h12345678);
    expect_val(2, "count_before_w5", 32'd0);

    drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h00000000, 5'd0, 5'd5, 5'd0);
    expect_val(3, "resultw_mem", 32'hDEADBEEF);
    expect_val(0, "rd1_r5", 32'h12345678);
    expect_val(2, "count_after_w5", 32'd1);

    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    expect_val(0, "r0_rd1", 32'd0);
    expect_val(1, "r0_rd2", 32'd0);
    expect_val(2, "count_r0_write", 32'd1);

    drive(1'b1, 1'b1, 32'hCAFEF00D, 32'h00000077, 5'd9, 5'd0, 5'd0);
    expect_val(2, "count_before_w9", 32'd1);

    drive(1'b0, 1'b0, 32'd0, 32'h00000055, 5'd10, 5'd9, 5'd9);
    expect_val(0, "same_addr_rd1", 32'hCAFEF00D);
    expect_val(1, "same_addr_rd2", 32'hCAFEF00D);
    expect_val(2, "count_after_w9", 32'd2);

    drive(1'b1, 1'b0, 32'd0, 32'h11111111, 5'd7, 5'd10, 5'd0);
    expect_val(0, "disabled_write_r10", 32'd0);
    expect_val(2, "count_no_we", 32'd2);

`ifdef WB_REGFILE_BYPASS_EN
    bypass_exp = 32'hA5A5A5A5;
`else
    bypass_exp = 32'h11111111;
`endif
    drive(1'b1, 1'b0, 32'd0, 32'hA5A5A5A5, 5'd7, 5'd5, 5'd7);
    expect_val(1, "same_cycle_r7", bypass_exp);
    expect_val(0, "rd1_r5_during_bypass", 32'h12345678);
    expect_val(2, "count_after_w7a", 32'd3);

    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7);
    expect_val(1, "r7_after_edge", 32'hA5A5A5A5);
    expect_val(2, "count_after_w7b", 32'd4);

    // Write to r3 on a reset edge is lost.
    drive(1'b1, 1'b0, 32'd0, 32'h33333333, 5'd3, 5'd3, 5'd5);
    rst = 1'b1;
    expect_val(0, "rst_cycle_rd1_r3", 32'd0);
    expect_val(1, "rst_cycle_rd2_r5", 32'h12345678);
    expect_val(2, "rst_cycle_count", 32'd4);

    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd5);
    rst = 1'b0;
    expect_val(0, "post_rst_r3", 32'd0);
    expect_val(1, "post_rst_r5", 32'd0);
    expect_val(2, "post_rst_count", 32'd0);

    drive(1'b1, 1'b0, 32'd0, 32'h00000044, 5'd4, 5'd7, 5'd9);
    expect_val(0, "post_rst_r7", 32'd0);
    expect_val(1, "post_rst_r9", 32'd0);
    expect_val(2, "post_rst_count2", 32'd0);

    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd4, 5'd0);
    expect_val(0, "r4_after_rst", 32'h00000044);
    expect_val(2, "count_after_w4", 32'd1);

    // Counter wrap via preload.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    force dut.wb_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wb_count_q;
    expect_val(2, "count_preload", 32'hFFFFFFFF);

    drive(1'b1, 1'b0, 32'd0, 32'h66666666, 5'd6, 5'd0, 5'd0);
    expect_val(2, "count_before_wrap", 32'hFFFFFFFF);

    drive(1'b1, 1'b1, 32'h99999999, 32'd0, 5'd0, 5'd6, 5'd0);
    expect_val(0, "r6_after_wrap", 32'h66666666);
    expect_val(2, "count_wrapped", 32'd0);

    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd6);
    expect_val(1, "r6_rd2", 32'h66666666);
    expect_val(2, "count_r0_after_wrap", 32'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of data words and write-back values.
REQ-002 Parameter NREG, default 32, SHALL set the number of architectural registers; address width is log2(NREG).
REQ-003 The block SHALL have one clock and a synchronous active-high reset, with these ports:
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- RegWriteW  in  1  write-back enable from the MEM/WB stage.
- MemtoRegW  in  1  1 selects Data_Mem_Out_W; 0 selects ALU_Out_W.
- Data_Mem_Out_W  in  DATA_W  load data from the MEM/WB stage.
- ALU_Out_W  in  DATA_W  ALU result from the MEM/WB stage.
- WriteRegW  in  5  destination register.
- A1  in  5  read address, port 1.
- A2  in  5  read address, port 2.
- RD1  out  DATA_W  read data, port 1.
- RD2  out  DATA_W  read data, port 2.
- ResultW  out  DATA_W  selected write-back value (also fed back for forwarding).
- wb_count  out  32  count of retired register writes.

Function
REQ-004 ResultW SHALL equal Data_Mem_Out_W when MemtoRegW=1, else ALU_Out_W, combinationally.
REQ-005 On posedge clk with rst=0, RegWriteW=1 and WriteRegW!=0, reg[WriteRegW] SHALL take ResultW.
REQ-006 Register 0 SHALL always read 0; writes to it SHALL be discarded.
REQ-007 RD1/RD2 SHALL be combinational reads of reg[A1]/reg[A2], subject to REQ-013.
REQ-008 The write latency SHALL be one edge: a value written at edge N is visible on RD1/RD2 after edge N.
REQ-009 wb_count SHALL increment by 1 on each edge where a write per REQ-005 occurs, and SHALL NOT increment for writes to r0 or when RegWriteW=0.
REQ-010 wb_count SHALL wrap from 0xFFFFFFFF to 0 without flagging.
REQ-011 A1=A2 SHALL return identical data on both ports.
REQ-012 Addresses at or above NREG (when NREG<32) SHALL read 0, and writes to them SHALL be discarded and not counted.

Reset
REQ-013 While rst=1 at posedge, all registers and wb_count SHALL clear to 0, and any concurrent write SHALL be discarded.
REQ-014 After reset, RD1, RD2 and wb_count SHALL read 0. ResultW is combinational and is not reset.
REQ-015 Asserting reset mid-stream SHALL lose only the write presented on the reset edge; there SHALL be no partially cleared state.

Configuration
REQ-016 With macro WB_REGFILE_BYPASS_EN defined, a read whose address equals WriteRegW (non-zero) while RegWriteW=1 SHALL return ResultW in the same cycle (write-before-read).
REQ-017 Without WB_REGFILE_BYPASS_EN, such a read SHALL return the old stored value until the next edge.
REQ-018 With the macro defined, bypass SHALL be suppressed while rst=1.

Structure
REQ-019 A shared package SHALL hold DATA_W and NREG defaults, the register-address width constant, and the r0 index constant.
REQ-020 The MemtoReg select SHALL be a sub-module wb_result_mux; storage, bypass and counter SHALL stay in wb_regfile.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then read all addresses -> every RD=0 and wb_count=0.
- RegWriteW=1, MemtoRegW=0, ALU_Out_W=0x12345678, WriteRegW=5; next cycle A1=5 -> RD1=0x12345678, wb_count=1.
- MemtoRegW=1, Data_Mem_Out_W=0xDEADBEEF, WriteRegW=0 -> RD(0)=0 and wb_count unchanged.
- Same-cycle write 0xA5A5A5A5 to r7 with A2=7 -> RD2=0xA5A5A5A5 with the bypass macro defined; RD2 holds the old value without it.
- Write r3 with rst=1 on the same edge -> r3=0 and wb_count=0.
- Preload wb_count to 0xFFFFFFFF via 2^32-1 writes (or force), then one valid write -> wb_count=0.
